// File: rtl/cu_pkg.sv
// Shared types and constants for the multi-cycle CPU control unit:
// opcodes, FSM states, function-unit selects and the datapath control word.
package cu_pkg;

  localparam int INSTR_W = 16;
  localparam int OPC_W   = 4;
  localparam int REG_W   = 4;
  localparam int IMM_W   = 16;

  localparam logic [OPC_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OPC_W-1:0] OP_ADD  = 4'h1;
  localparam logic [OPC_W-1:0] OP_SUB  = 4'h2;
  localparam logic [OPC_W-1:0] OP_AND  = 4'h3;
  localparam logic [OPC_W-1:0] OP_OR   = 4'h4;
  localparam logic [OPC_W-1:0] OP_XOR  = 4'h5;
  localparam logic [OPC_W-1:0] OP_NOT  = 4'h6;
  localparam logic [OPC_W-1:0] OP_MOV  = 4'h7;
  localparam logic [OPC_W-1:0] OP_ADDI = 4'h8;
  localparam logic [OPC_W-1:0] OP_LD   = 4'h9;
  localparam logic [OPC_W-1:0] OP_ST   = 4'hA;
  localparam logic [OPC_W-1:0] OP_BRZ  = 4'hB;
  localparam logic [OPC_W-1:0] OP_BRN  = 4'hC;
  localparam logic [OPC_W-1:0] OP_JMP  = 4'hD;
  localparam logic [OPC_W-1:0] OP_SHR  = 4'hE;
  localparam logic [OPC_W-1:0] OP_HALT = 4'hF;

  localparam logic [3:0] FS_MOVA = 4'h0;
  localparam logic [3:0] FS_ADD  = 4'h2;
  localparam logic [3:0] FS_SUB  = 4'h5;
  localparam logic [3:0] FS_AND  = 4'h8;
  localparam logic [3:0] FS_OR   = 4'h9;
  localparam logic [3:0] FS_XOR  = 4'hA;
  localparam logic [3:0] FS_NOT  = 4'hB;
  localparam logic [3:0] FS_SHR  = 4'hD;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_FETCH,
    ST_EXEC,
    ST_MEM,
    ST_HALT
  } state_e;

  typedef struct packed {
    logic [REG_W-1:0] dest_sel;
    logic [REG_W-1:0] a_sel;
    logic [REG_W-1:0] b_sel;
    logic [3:0]       op_sel;
    logic             load_en;
    logic             data_sel;
    logic             const_sel;
    logic [IMM_W-1:0] const_in;
  } ctrl_t;

  // Function-unit select for every opcode that writes rd through the ALU.
  function automatic logic [3:0] alu_fs(input logic [OPC_W-1:0] opc);
    case (opc)
      OP_ADD, OP_ADDI: return FS_ADD;
      OP_SUB:          return FS_SUB;
      OP_AND:          return FS_AND;
      OP_OR:           return FS_OR;
      OP_XOR:          return FS_XOR;
      OP_NOT:          return FS_NOT;
      OP_SHR:          return FS_SHR;
      default:         return FS_MOVA;
    endcase
  endfunction

  function automatic logic is_arith(input logic [OPC_W-1:0] opc);
    return (opc == OP_ADD) || (opc == OP_SUB) || (opc == OP_ADDI);
  endfunction

endpackage

// File: rtl/cpu_control_unit_if.sv
// Instruction-fetch and data-memory handshake bundle between the control
// unit (master) and the memory side (slave).
interface cpu_control_unit_if #(
  parameter int ADDR_W = 8
);
  logic [15:0]       instr_data;
  logic              instr_valid;
  logic              instr_req;
  logic [ADDR_W-1:0] pc;
  logic              mem_req;
  logic              mem_we;
  logic              mem_ready;

  modport master (
    input  instr_data, instr_valid, mem_ready,
    output instr_req, pc, mem_req, mem_we
  );

  modport slave (
    output instr_data, instr_valid, mem_ready,
    input  instr_req, pc, mem_req, mem_we
  );
endinterface

// File: rtl/cu_decoder.sv
// Purely combinational decode of FSM state + instruction register into the
// datapath control word and the fetch/memory request strobes.
module cu_decoder
  import cu_pkg::*;
(
  input  state_e             state,
  input  logic [INSTR_W-1:0] ir,
  input  logic               mem_ready,
  input  logic               ovf,
  output ctrl_t              ctrl,
  output logic               instr_req,
  output logic               mem_req,
  output logic               mem_we,
  output logic               halted
);

  logic [OPC_W-1:0] opc;
  logic [REG_W-1:0] rd, ra, rb;

  assign opc = ir[15:12];
  assign rd  = ir[11:8];
  assign ra  = ir[7:4];
  assign rb  = ir[3:0];

  always_comb begin
    ctrl      = '0;
    instr_req = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    halted    = 1'b0;
    case (state)
      ST_FETCH: instr_req = 1'b1;
      ST_EXEC: begin
        case (opc)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_MOV, OP_SHR,
          OP_ADDI: begin
            ctrl.dest_sel = rd;
            ctrl.a_sel    = ra;
            ctrl.b_sel    = rb;
            ctrl.op_sel   = alu_fs(opc);
            ctrl.load_en  = !ovf;
            if (opc == OP_ADDI) begin
              ctrl.const_sel = 1'b1;
              ctrl.const_in  = {{(IMM_W-REG_W){1'b0}}, rb};
            end
          end
          // Branches pass ra through the ALU so Z/N reflect its value.
          OP_BRZ, OP_BRN: begin
            ctrl.a_sel  = ra;
            ctrl.op_sel = FS_MOVA;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        mem_req    = 1'b1;
        mem_we     = (opc == OP_ST);
        ctrl.a_sel = ra;
        ctrl.b_sel = rb;
        if (opc == OP_LD) begin
          ctrl.dest_sel = rd;
          ctrl.data_sel = 1'b1;
          ctrl.load_en  = mem_ready;
        end
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle control unit: FSM, PC and IR; decode lives in cu_decoder.
// Optional overflow trap on ADD/SUB/ADDI is enabled by defining CU_OVF_TRAP_EN.
module cpu_control_unit
  import cu_pkg::*;
#(
  parameter int          ADDR_W   = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  cpu_control_unit_if.master  bus,
  input  logic                V,
  input  logic                C,
  input  logic                N,
  input  logic                Z,
  output logic [REG_W-1:0]    dest_sel,
  output logic [REG_W-1:0]    A_sel,
  output logic [REG_W-1:0]    B_sel,
  output logic [3:0]          op_sel,
  output logic                load_en,
  output logic                data_sel,
  output logic                const_sel,
  output logic [IMM_W-1:0]    const_in,
  output logic                halted,
  output logic                trap
);

  localparam logic [ADDR_W-1:0] RESET_PC_V = ADDR_W'(RESET_PC);

  state_e             state, state_nxt;
  logic [ADDR_W-1:0]  pc_q, pc_nxt, pc_inc, br_off, jmp_tgt;
  logic [INSTR_W-1:0] ir_q, ir_nxt;
  logic [OPC_W-1:0]   opc;
  logic               ovf_trap;
  logic               unused_flags;
  ctrl_t              ctrl;

  assign opc     = ir_q[15:12];
  assign pc_inc  = pc_q + ADDR_W'(1);
  // Branch offset {rd,rb} is a signed byte; jump target is that byte unsigned.
  assign br_off  = ADDR_W'({{ADDR_W{ir_q[11]}}, ir_q[11:8], ir_q[3:0]});
  assign jmp_tgt = ADDR_W'({{ADDR_W{1'b0}}, ir_q[11:8], ir_q[3:0]});

`ifdef CU_OVF_TRAP_EN
  logic trap_q;

  assign ovf_trap     = (state == ST_EXEC) && is_arith(opc) && V;
  assign trap         = trap_q;
  assign unused_flags = C;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        trap_q <= 1'b0;
    else if (ovf_trap) trap_q <= 1'b1;
  end
`else
  assign ovf_trap     = 1'b0;
  assign trap         = 1'b0;
  assign unused_flags = ^{V, C};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_BOOT;
      pc_q  <= RESET_PC_V;
      ir_q  <= '0;
    end else begin
      state <= state_nxt;
      pc_q  <= pc_nxt;
      ir_q  <= ir_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    ir_nxt    = ir_q;
    case (state)
      ST_BOOT: state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (bus.instr_valid) begin
          ir_nxt    = bus.instr_data;
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_nxt = ST_FETCH;
        pc_nxt    = pc_inc;
        if (ovf_trap) begin
          state_nxt = ST_HALT;
          pc_nxt    = pc_q;
        end else begin
          case (opc)
            OP_LD, OP_ST: state_nxt = ST_MEM;
            OP_BRZ:       if (Z) pc_nxt = pc_inc + br_off;
            OP_BRN:       if (N) pc_nxt = pc_inc + br_off;
            OP_JMP:       pc_nxt = jmp_tgt;
            OP_HALT: begin
              state_nxt = ST_HALT;
              pc_nxt    = pc_q;
            end
            default: ;
          endcase
        end
      end
      ST_MEM:  if (bus.mem_ready) state_nxt = ST_FETCH;
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_BOOT;
    endcase
  end

  cu_decoder u_decoder (
    .state     (state),
    .ir        (ir_q),
    .mem_ready (bus.mem_ready),
    .ovf       (ovf_trap),
    .ctrl      (ctrl),
    .instr_req (bus.instr_req),
    .mem_req   (bus.mem_req),
    .mem_we    (bus.mem_we),
    .halted    (halted)
  );

  assign bus.pc    = pc_q;
  assign dest_sel  = ctrl.dest_sel;
  assign A_sel     = ctrl.a_sel;
  assign B_sel     = ctrl.b_sel;
  assign op_sel    = ctrl.op_sel;
  assign load_en   = ctrl.load_en;
  assign data_sel  = ctrl.data_sel;
  assign const_sel = ctrl.const_sel;
  assign const_in  = ctrl.const_in;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Self-checking bench for cpu_control_unit: directed program steps followed by
// a random instruction stream, checked cycle by cycle against a transaction model.
module tb_cpu_control_unit;

  localparam int ADDR_W = 8;

  typedef struct packed {
    logic        instr_req;
    logic [7:0]  pc;
    logic [3:0]  dest;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [3:0]  op;
    logic        load_en;
    logic        data_sel;
    logic        const_sel;
    logic [15:0] const_in;
    logic        mem_req;
    logic        mem_we;
    logic        halted;
    logic        trap;
  } outs_t;

  logic clk = 1'b0;
  logic rst_n;
  logic V, C, N, Z;
  logic [3:0]  dest_sel, A_sel, B_sel, op_sel;
  logic        load_en, data_sel, const_sel, halted, trap;
  logic [15:0] const_in;

  always #5 clk = ~clk;

  cpu_control_unit_if #(.ADDR_W(ADDR_W)) bus ();

  cpu_control_unit #(.ADDR_W(ADDR_W), .RESET_PC(0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .V         (V),
    .C         (C),
    .N         (N),
    .Z         (Z),
    .dest_sel  (dest_sel),
    .A_sel     (A_sel),
    .B_sel     (B_sel),
    .op_sel    (op_sel),
    .load_en   (load_en),
    .data_sel  (data_sel),
    .const_sel (const_sel),
    .const_in  (const_in),
    .halted    (halted),
    .trap      (trap)
  );

  outs_t obs;
  assign obs = {bus.instr_req, bus.pc, dest_sel, A_sel, B_sel, op_sel, load_en,
                data_sel, const_sel, const_in, bus.mem_req, bus.mem_we, halted, trap};

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] model_pc;
  logic       model_trap;
  logic       model_halted;

  localparam outs_t ALL_BITS = '1;
  localparam outs_t NO_PC    = {1'b1, 8'h00, 39'h7F_FFFF_FFFF};

  task automatic checkOutput(input string tag, input outs_t got, input outs_t want,
                             input outs_t mask);
    n_cmp++;
    assert ((got & mask) === (want & mask)) else begin
      n_bad++;
      $error("[TB] FAIL %s: observed %h required %h (mask %h)", tag, got, want, mask);
    end
  endtask

  // Reference model: output expectations derived from the instruction-set rules.
  function automatic logic [3:0] fsFor(input logic [3:0] opc);
    case (opc)
      4'h1, 4'h8: return 4'h2;
      4'h2:       return 4'h5;
      4'h3:       return 4'h8;
      4'h4:       return 4'h9;
      4'h5:       return 4'hA;
      4'h6:       return 4'hB;
      4'hE:       return 4'hD;
      default:    return 4'h0;
    endcase
  endfunction

  function automatic logic writesRd(input logic [3:0] opc);
    return (opc >= 4'h1 && opc <= 4'h8) || opc == 4'hE;
  endfunction

  function automatic logic trapHits(input logic [3:0] opc, input logic v);
`ifdef CU_OVF_TRAP_EN
    return v && (opc == 4'h1 || opc == 4'h2 || opc == 4'h8);
`else
    return 1'b0 & v & opc[0];
`endif
  endfunction

  function automatic outs_t fetchOuts(input logic [7:0] pc);
    outs_t o = '0;
    o.instr_req = 1'b1;
    o.pc        = pc;
    return o;
  endfunction

  function automatic outs_t execOuts(input logic [7:0] pc, input logic [15:0] ins,
                                     input logic v);
    outs_t o = '0;
    logic [3:0] opc = ins[15:12];
    o.pc = pc;
    if (writesRd(opc)) begin
      o.dest    = ins[11:8];
      o.a       = ins[7:4];
      o.b       = ins[3:0];
      o.op      = fsFor(opc);
      o.load_en = !trapHits(opc, v);
      if (opc == 4'h8) begin
        o.const_sel = 1'b1;
        o.const_in  = {12'h000, ins[3:0]};
      end
    end else if (opc == 4'hB || opc == 4'hC) begin
      o.a = ins[7:4];
    end
    return o;
  endfunction

  function automatic outs_t memOuts(input logic [7:0] pc, input logic [15:0] ins,
                                    input logic ready);
    outs_t o = '0;
    o.pc      = pc;
    o.mem_req = 1'b1;
    o.mem_we  = (ins[15:12] == 4'hA);
    o.a       = ins[7:4];
    o.b       = ins[3:0];
    if (ins[15:12] == 4'h9) begin
      o.dest     = ins[11:8];
      o.data_sel = 1'b1;
      o.load_en  = ready;
    end
    return o;
  endfunction

  function automatic logic [7:0] nextPc(input logic [7:0] pc, input logic [15:0] ins,
                                        input logic n, input logic z);
    int off = int'({ins[11:8], ins[3:0]});
    if (off >= 128) off = off - 256;
    case (ins[15:12])
      4'hB:    return z ? 8'(int'(pc) + 1 + off) : pc + 8'd1;
      4'hC:    return n ? 8'(int'(pc) + 1 + off) : pc + 8'd1;
      4'hD:    return {ins[11:8], ins[3:0]};
      4'hF:    return pc;
      default: return pc + 8'd1;
    endcase
  endfunction

  // One full instruction: fetch wait cycles, EXEC, then any MEM cycles.
  task automatic applyStimulus(input logic [15:0] ins, input int fwait, input int mwait,
                               input logic v, input logic n, input logic z);
    logic [3:0] opc = ins[15:12];
    for (int i = 0; i < fwait; i++) begin
      @(negedge clk);
      bus.instr_valid = 1'b0;
      bus.instr_data  = 16'($urandom);
      bus.mem_ready   = 1'b0;
      {V, C, N, Z}    = 4'($urandom);
      #1 checkOutput("fetch_wait", obs, fetchOuts(model_pc), ALL_BITS);
    end
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr_data  = ins;
    bus.mem_ready   = 1'b0;
    #1 checkOutput("fetch_valid", obs, fetchOuts(model_pc), ALL_BITS);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    bus.instr_data  = 16'($urandom);
    V = v; N = n; Z = z; C = 1'($urandom);
    #1 checkOutput("exec", obs, execOuts(model_pc, ins, v), ALL_BITS);
    if (trapHits(opc, v) || opc == 4'hF) begin
      model_trap   = trapHits(opc, v);
      model_halted = 1'b1;
      return;
    end
    model_pc = nextPc(model_pc, ins, n, z);
    if (opc == 4'h9 || opc == 4'hA) begin
      for (int i = 0; i < mwait; i++) begin
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1 checkOutput("mem_wait", obs, memOuts(model_pc, ins, 1'b0), ALL_BITS);
      end
      @(negedge clk);
      bus.mem_ready = 1'b1;
      #1 checkOutput("mem_ready", obs, memOuts(model_pc, ins, 1'b1), ALL_BITS);
    end
  endtask

  initial begin
    outs_t hexp;
    logic  rv;
    rst_n = 1'b0;
    {V, C, N, Z} = 4'h0;
    bus.instr_valid = 1'b0;
    bus.instr_data  = 16'h0000;
    bus.mem_ready   = 1'b0;
    model_pc     = 8'h00;
    model_trap   = 1'b0;
    model_halted = 1'b0;

    @(negedge clk);
    #1 checkOutput("reset_hold", obs, '0, ALL_BITS);
    @(negedge clk);
    rst_n = 1'b1;
    #1 checkOutput("boot", obs, '0, ALL_BITS);

    applyStimulus(16'h1312, 3, 0, 1'b0, 1'b0, 1'b0);
    applyStimulus(16'h9450, 0, 2, 1'b0, 1'b0, 1'b0);
    applyStimulus(16'hA056, 1, 1, 1'b0, 1'b0, 1'b0);
    applyStimulus(16'h8A37, 0, 0, 1'b0, 1'b0, 1'b0);
    applyStimulus(16'hD005, 0, 0, 1'b0, 1'b0, 1'b0);
    applyStimulus(16'hBF2E, 0, 0, 1'b0, 1'b0, 1'b1);
    applyStimulus(16'hD005, 0, 0, 1'b0, 1'b0, 1'b0);
    applyStimulus(16'hBF2E, 0, 0, 1'b0, 1'b0, 1'b0);
    applyStimulus(16'hDF0F, 0, 0, 1'b0, 1'b0, 1'b0);
    applyStimulus(16'hB001, 0, 0, 1'b0, 1'b0, 1'b1);
    applyStimulus(16'hC312, 2, 0, 1'b0, 1'b1, 1'b0);

    for (int k = 0; k < 60; k++) begin
      logic [15:0] ins;
      ins = {4'($urandom_range(0, 14)), 12'($urandom)};
`ifdef CU_OVF_TRAP_EN
      rv = 1'b0;
`else
      rv = 1'($urandom);
`endif
      applyStimulus(ins, $urandom_range(0, 3), $urandom_range(0, 3), rv,
                    1'($urandom), 1'($urandom));
    end

    // Reset pulled in the middle of a load's memory wait.
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr_data  = 16'h9450;
    bus.mem_ready   = 1'b0;
    #1 checkOutput("rst_fetch", obs, fetchOuts(model_pc), ALL_BITS);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    #1 checkOutput("rst_exec", obs, execOuts(model_pc, 16'h9450, V), ALL_BITS);
    model_pc = model_pc + 8'd1;
    @(negedge clk);
    #1 checkOutput("rst_mem", obs, memOuts(model_pc, 16'h9450, 1'b0), ALL_BITS);
    #2 rst_n = 1'b0;
    #1 checkOutput("rst_async_drop", obs, '0, ALL_BITS);
    model_pc = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    #1 checkOutput("rst_boot", obs, '0, ALL_BITS);

    applyStimulus(16'h1312, 1, 0, 1'b1, 1'b0, 1'b0);
    if (!model_halted) applyStimulus(16'hF000, 2, 0, 1'b0, 1'b0, 1'b0);

    hexp = '0;
    hexp.halted = 1'b1;
    hexp.trap   = model_trap;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      bus.instr_valid = 1'($urandom);
      bus.instr_data  = 16'($urandom);
      bus.mem_ready   = 1'($urandom);
      {V, C, N, Z}    = 4'($urandom);
      #1 checkOutput("halted", obs, hexp, NO_PC);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
